// File: rtl/osd_stm_event_rx_pkg.sv
// Shared debug-interconnect flit type and STM event definitions.
// Used by the STM event receiver and its depacketizer.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

package opensocdebug;

    localparam logic [1:0] osd_event_type = 2'b10;
    localparam int FLAGS_TYPE_MSB = 15;
    localparam int FLAGS_TYPE_LSB = 14;

    // value is sized for the widest supported trace value
    typedef struct packed {
        logic [15:0] src;
        logic [31:0] timestamp;
        logic [15:0] id;
        logic [63:0] value;
    } stm_event;

endpackage

// File: rtl/osd_stm_event_rx_depacketization.sv
// Generic DII event depacketizer: header check, payload capture,
// truncation/overlong detection.
module osd_event_depacketization
    import dii_package::*;
    import opensocdebug::*;
#(
    parameter int PAYLOAD_WORDS = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [15:0]                 id,
    input  dii_flit                     flit,
    input  logic                        out_stall,
    output logic                        in_ready,
    output logic                        done,
    output logic                        drop,
    output logic [15:0]                 src,
    output logic [PAYLOAD_WORDS*16-1:0] payload
);

    localparam int P  = PAYLOAD_WORDS;
    localparam int CW = $clog2(P);

    typedef enum logic [2:0] {
        DEST,
        SRC,
        FLAGS,
        PAYLOAD,
        DROP
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [P-2:0][15:0]  words;
    logic [15:0]         src_q;
    logic                at_end;
    logic                accept;
    logic                type_ok;

    assign at_end   = (state == PAYLOAD) && (cnt == CW'(P - 1));
    assign in_ready = !(at_end && out_stall);
    assign accept   = flit.valid && in_ready;
    assign type_ok  = flit.data[FLAGS_TYPE_MSB:FLAGS_TYPE_LSB] == osd_event_type;

    // every packet ends in exactly one of done or drop
    assign done    = accept && at_end && flit.last;
    assign drop    = accept && flit.last && !at_end;
    assign src     = src_q;
    assign payload = {flit.data, words};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DEST;
            cnt   <= '0;
            words <= '0;
            src_q <= '0;
        end else if (accept) begin
            case (state)
                DEST: begin
                    if (flit.last)
                        state <= DEST;
                    else if (flit.data != id)
                        state <= DROP;
                    else
                        state <= SRC;
                end
                SRC: begin
                    src_q <= flit.data;
                    state <= flit.last ? DEST : FLAGS;
                end
                FLAGS: begin
                    if (flit.last)
                        state <= DEST;
                    else if (!type_ok)
                        state <= DROP;
                    else begin
                        state <= PAYLOAD;
                        cnt   <= '0;
                    end
                end
                PAYLOAD: begin
                    if (at_end) begin
                        state <= flit.last ? DEST : DROP;
                    end else begin
                        for (int i = 0; i < P - 1; i++)
                            if (cnt == CW'(i))
                                words[i] <= flit.data;
                        cnt <= cnt + 1'b1;
                        if (flit.last)
                            state <= DEST;
                    end
                end
                DROP: begin
                    if (flit.last)
                        state <= DEST;
                end
                default: state <= DEST;
            endcase
        end
    end

endmodule

// File: rtl/osd_stm_event_rx.sv
// STM event receiver: turns DII event packets into trace events
// on a valid/ready output and counts discarded packets.
module osd_stm_event_rx
    import dii_package::*;
#(
    parameter int VALWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         id,
    input  dii_flit             debug_in,
    output logic                debug_in_ready,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [15:0]         event_src,
    output logic [31:0]         event_timestamp,
    output logic [15:0]         event_id,
    output logic [VALWIDTH-1:0] event_value,
    output logic [15:0]         drop_count
);

    localparam int P = 3 + VALWIDTH / 16;

    logic           done;
    logic           drop;
    logic           stall;
    logic [15:0]    src;
    logic [P*16-1:0] payload;

    assign stall = event_valid && !event_ready;

    osd_event_depacketization #(
        .PAYLOAD_WORDS(P)
    ) u_depack (
        .clk      (clk),
        .rst_n    (rst_n),
        .id       (id),
        .flit     (debug_in),
        .out_stall(stall),
        .in_ready (debug_in_ready),
        .done     (done),
        .drop     (drop),
        .src      (src),
        .payload  (payload)
    );

    // completion wins over consumption so a same-cycle reload keeps valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_valid     <= 1'b0;
            event_src       <= '0;
            event_timestamp <= '0;
            event_id        <= '0;
            event_value     <= '0;
        end else if (done) begin
            event_valid     <= 1'b1;
            event_src       <= src;
            event_timestamp <= payload[31:0];
            event_id        <= payload[47:32];
            event_value     <= payload[P*16-1:48];
        end else if (event_ready) begin
            event_valid     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
    end

endmodule

// File: tb/tb_osd_stm_event_rx.sv
// Scoreboard bench for the STM event receiver with a packet-level
// reference model and randomized traffic.
module tb_osd_stm_event_rx;
    import dii_package::*;
    import opensocdebug::*;

    localparam int VW  = 32;
    localparam int NV  = VW / 16;
    localparam int P   = 3 + NV;
    localparam int LEN = 3 + P;
    localparam logic [15:0] MY_ID = 16'h0005;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    dii_flit       debug_in = '0;
    logic          debug_in_ready;
    logic          event_valid;
    logic          event_ready = 1'b1;
    logic [15:0]   event_src;
    logic [31:0]   event_timestamp;
    logic [15:0]   event_id;
    logic [VW-1:0] event_value;
    logic [15:0]   drop_count;

    always #5 clk = ~clk;

    osd_stm_event_rx #(
        .VALWIDTH(VW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id             (MY_ID),
        .debug_in       (debug_in),
        .debug_in_ready (debug_in_ready),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_src      (event_src),
        .event_timestamp(event_timestamp),
        .event_id       (event_id),
        .event_value    (event_value),
        .drop_count     (drop_count)
    );

    int checks = 0;
    int failures = 0;
    int exp_drops = 0;
    int cyc = 0;
    int ready_mode = 1;
    int stalls = 0;
    stm_event expq[$];
    int cons_cyc[$];
    logic [15:0] pkt[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=progress", name);
    endtask

    // 0: stall consumer, 1: always ready, 2: random
    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 0)
            event_ready = 1'b0;
        else if (ready_mode == 1)
            event_ready = 1'b1;
        else
            event_ready = ($urandom % 4) != 0;
    end

    initial forever begin
        stm_event e;
        @(negedge clk);
        if (rst_n && event_valid && event_ready) begin
            cons_cyc.push_back(cyc);
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=valid required=none");
            end else begin
                e = expq.pop_front();
                check("event_src", 64'(event_src), 64'(e.src));
                check("event_ts", 64'(event_timestamp), 64'(e.timestamp));
                check("event_id", 64'(event_id), 64'(e.id));
                check("event_value", 64'(event_value), e.value);
            end
        end
    end

    // a packet yields an event only if it is addressed here, typed as
    // an event and exactly LEN flits long; anything else counts a drop
    task automatic expect_pkt();
        stm_event e;
        if (pkt.size() == LEN && pkt[0] == MY_ID && pkt[2][15:14] == 2'b10) begin
            e.src       = pkt[1];
            e.timestamp = {pkt[4], pkt[3]};
            e.id        = pkt[5];
            e.value     = '0;
            for (int k = 0; k < NV; k++)
                e.value = e.value | (64'(pkt[6 + k]) << (16 * k));
            expq.push_back(e);
        end else if (exp_drops < 65535) begin
            exp_drops++;
        end
    endtask

    task automatic send_flit(input logic [15:0] d, input logic l);
        int n;
        debug_in = '{valid: 1'b1, last: l, data: d};
        n = 0;
        @(negedge clk);
        if (!debug_in_ready)
            stalls++;
        while (!debug_in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000)
            fail("ready_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic send_packet(input int gap_max);
        expect_pkt();
        for (int i = 0; i < pkt.size(); i++) begin
            send_flit(pkt[i], i == pkt.size() - 1);
            if (gap_max > 0 && ($urandom % 3) == 0) begin
                debug_in.valid = 1'b0;
                repeat ($urandom_range(gap_max, 1)) @(posedge clk);
                #1;
            end
        end
        debug_in.valid = 1'b0;
    endtask

    task automatic gen_packet(input int kind);
        int len;
        case (kind)
            0: len = LEN;
            1: len = $urandom_range(10, 1);
            2: len = $urandom_range(10, 3);
            3: len = $urandom_range(LEN - 1, 1);
            default: len = $urandom_range(LEN + 3, LEN + 1);
        endcase
        pkt.delete();
        for (int i = 0; i < len; i++)
            pkt.push_back(16'($urandom));
        pkt[0] = MY_ID;
        if (len > 2)
            pkt[2][15:14] = 2'b10;
        if (kind == 1)
            pkt[0] = MY_ID ^ 16'($urandom_range(16'hFFFF, 1));
        if (kind == 2)
            pkt[2][15:14] = 2'($urandom_range(2, 0)) ^ 2'b10 ^ 2'b10 == 2'b10
                            ? 2'b11 : 2'($urandom_range(1, 0));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000)
            fail("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
        check("drop_count", 64'(drop_count), 64'(exp_drops));
    endtask

    initial begin
        int base;
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(debug_in_ready), 64'd1);
        check("rst_valid", 64'(event_valid), 64'd0);
        check("rst_drops", 64'(drop_count), 64'd0);
        check("rst_fields", {event_src, event_id, event_timestamp}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pkt = '{16'h0005, 16'h0010, 16'h8000, 16'h1234,
                16'h0000, 16'h0015, 16'hBEEF, 16'hDEAD};
        send_packet(0);
        check("latency_valid", 64'(event_valid), 64'd1);
        drain();

        pkt = '{16'h0006, 16'h0010, 16'h8000, 16'h1234,
                16'h0000, 16'h0015, 16'hBEEF, 16'hDEAD};
        send_packet(0);
        drain();
        gen_packet(0);
        send_packet(0);
        drain();

        pkt = '{16'h0005, 16'h0010, 16'h8000, 16'h1234, 16'h0000};
        send_packet(0);
        drain();
        gen_packet(4);
        pkt = pkt[0:LEN];
        send_packet(0);
        gen_packet(0);
        send_packet(0);
        drain();

        pkt = '{16'h0005, 16'h0010, 16'h4000, 16'h1234,
                16'h0000, 16'h0015, 16'hBEEF, 16'hDEAD};
        send_packet(0);
        drain();

        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            gen_packet(($urandom % 3) == 0 ? $urandom_range(4, 1) : 0);
            send_packet(2);
        end
        ready_mode = 1;
        drain();

        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        gen_packet(0);
        send_packet(0);
        gen_packet(0);
        expect_pkt();
        base = stalls;
        for (int i = 0; i < LEN - 1; i++)
            send_flit(pkt[i], 1'b0);
        check("bp_no_early_stall", 64'(stalls), 64'(base));
        debug_in = '{valid: 1'b1, last: 1'b1, data: pkt[LEN - 1]};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_low", 64'(debug_in_ready), 64'd0);
        end
        ready_mode = 1;
        n = 0;
        while (!debug_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100)
            fail("bp_release");
        @(posedge clk);
        #1;
        debug_in.valid = 1'b0;
        drain();

        cons_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            gen_packet(0);
            send_packet(0);
        end
        drain();
        check("b2b_events", 64'(cons_cyc.size()), 64'd4);
        if (cons_cyc.size() == 4)
            for (int i = 1; i < 4; i++)
                check("b2b_spacing", 64'(cons_cyc[i] - cons_cyc[i - 1]), 64'd8);

        debug_in = '{valid: 1'b1, last: 1'b1, data: 16'h0006};
        repeat (70000) @(posedge clk);
        #1;
        debug_in.valid = 1'b0;
        exp_drops = (exp_drops + 70000 > 65535) ? 65535 : exp_drops + 70000;
        repeat (2) @(posedge clk);
        #1;
        check("drop_saturate", 64'(drop_count), 64'(exp_drops));

        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        gen_packet(0);
        send_packet(0);
        gen_packet(0);
        for (int i = 0; i < 5; i++)
            send_flit(pkt[i], 1'b0);
        debug_in.valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(event_valid), 64'd0);
        check("mid_rst_ready", 64'(debug_in_ready), 64'd1);
        check("mid_rst_drops", 64'(drop_count), 64'd0);
        check("mid_rst_src_id", {32'd0, event_src, event_id}, 64'd0);
        check("mid_rst_ts_val", {event_timestamp, event_value}, 64'd0);
        expq.delete();
        exp_drops = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 1;
        pkt = pkt[5:LEN - 1];
        send_packet(0);
        gen_packet(0);
        send_packet(0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
